// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage between execute and the mmu.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [1:0]  resp_cause,
  output logic [31:0] resp_addr,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic        mem_signed_read,
  output logic [1:0]  mem_data_width,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic [31:0] eff_addr;
  logic [1:0]  dec_width;
  logic        dec_illegal;
  logic        wr_q;
  logic [7:0]  cnt;
  logic        accept;
  logic        fire;
  logic        cnt_inc;
  logic [1:0]  cause_nx;
  logic [31:0] rdata_nx;
  logic [31:0] addr_nx;

  assign eff_addr = req_base + req_offset;
  assign req_ready = (state == IDLE);

  // Enables follow the state so an async reset drops them at once.
  assign mem_read_enable  = (state == ISSUE) && !wr_q;
  assign mem_write_enable = (state == ISSUE) && wr_q;

  // funct3 -> mmu width; 11 and signed-looking stores are illegal.
  always_comb begin
    dec_width   = {req_funct3[1], req_funct3[1] | req_funct3[0]};
    dec_illegal = (req_funct3[1:0] == 2'b11)
                | (req_write & req_funct3[2]);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic dec_misal;

  // Half needs bit 0 clear, word needs bits 1:0 clear.
  always_comb begin
    dec_misal = 1'b0;
    unique case (1'b1)
      (dec_width == 2'd1): dec_misal = eff_addr[0];
      (dec_width == 2'd3): dec_misal = |eff_addr[1:0];
      default:             dec_misal = 1'b0;
    endcase
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state and the response to load on this edge.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    fire     = 1'b0;
    cnt_inc  = 1'b0;
    cause_nx = 2'd0;
    rdata_nx = 32'h0;
    addr_nx  = mem_address;
    unique case (state)
      IDLE: begin
        addr_nx = eff_addr;
        if (req_valid) begin
          accept = 1'b1;
          if (dec_illegal) begin
            fire     = 1'b1;
            cause_nx = 2'd2;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (dec_misal) begin
            fire     = 1'b1;
            cause_nx = 2'd1;
          end
`endif
          else begin
            state_nx = ISSUE;
          end
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (mem_ready) begin
          fire     = 1'b1;
          rdata_nx = wr_q ? 32'h0 : mem_data_out;
          state_nx = IDLE;
        end else if (cnt == TO_LAST) begin
          fire     = 1'b1;
          cause_nx = 2'd3;
          state_nx = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counts consecutive WAIT cycles without mem_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     cnt <= 8'd0;
    else if (cnt_inc) cnt <= cnt + 8'd1;
    else              cnt <= 8'd0;
  end

  // mmu holding registers, loaded once per accepted request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q            <= 1'b0;
      mem_address     <= 32'h0;
      mem_data_width  <= 2'd0;
      mem_signed_read <= 1'b0;
      mem_data_in     <= 32'h0;
    end else if (accept) begin
      wr_q            <= req_write;
      mem_address     <= eff_addr;
      mem_data_width  <= dec_width;
      mem_signed_read <= !req_funct3[2];
      mem_data_in     <= req_wdata;
    end
  end

  // Response pulse; payload holds until the next response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_exc   <= 1'b0;
      resp_cause <= 2'd0;
      resp_addr  <= 32'h0;
    end else begin
      resp_valid <= fire;
      if (fire) begin
        resp_rdata <= rdata_nx;
        resp_exc   <= (cause_nx != 2'd0);
        resp_cause <= cause_nx;
        resp_addr  <= addr_nx;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: vector table plus scoreboard for load_store_unit.
// A small byte-addressed mmu model answers the issued requests.
module tb_load_store_unit;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [1:0]  resp_cause;
  logic [31:0] resp_addr;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic        mem_signed_read;
  logic [1:0]  mem_data_width;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_ready;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_base         (req_base),
    .req_offset       (req_offset),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_exc         (resp_exc),
    .resp_cause       (resp_cause),
    .resp_addr        (resp_addr),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_signed_read  (mem_signed_read),
    .mem_data_width   (mem_data_width),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_data_out     (mem_data_out),
    .mem_ready        (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] wdata;
    int          xd;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [1:0]  cause;
    int          lat;
    logic [1:0]  ew;
    logic        es;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        exc;
    logic [1:0]  cause;
    logic [31:0] addr;
  } rsp_t;

  int   nchk = 0;
  int   nerr = 0;
  int   cur  = 0;
  int   xdelay = 0;
  rsp_t sbq[$];
  vec_t vecs[$];

  logic [31:0] ram [logic [29:0]];
  logic [31:0] m_val;
  int          m_zeros;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL vec%0d %s: got %h expected %h", cur, n, act, exp);
    end
  endtask

  function automatic logic [31:0] rdw(input logic [29:0] w);
    if (ram.exists(w)) return ram[w];
    return 32'h0;
  endfunction

  function automatic logic [31:0] mmu_read(input logic [31:0] a,
                                           input logic [1:0] wd,
                                           input logic sg);
    logic [63:0] d;
    d = {rdw(a[31:2] + 30'd1), rdw(a[31:2])} >> {a[1:0], 3'b000};
    case (wd)
      2'd0:    return sg ? {{24{d[7]}}, d[7:0]} : {24'h0, d[7:0]};
      2'd1:    return sg ? {{16{d[15]}}, d[15:0]} : {16'h0, d[15:0]};
      default: return d[31:0];
    endcase
  endfunction

  task automatic mmu_write(input logic [31:0] a, input logic [31:0] dat,
                           input logic [1:0] wd);
    int n;
    n = (wd == 2'd0) ? 1 : (wd == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      logic [31:0] ba;
      logic [31:0] w;
      ba = a + 32'(i);
      w = rdw(ba[31:2]);
      w[8*ba[1:0] +: 8] = dat[8*i +: 8];
      ram[ba[31:2]] = w;
    end
  endtask

  // mmu model: fast for aligned reads and word writes, one extra
  // not-ready cycle otherwise, plus xdelay; xdelay >= 8 never answers.
  initial begin
    mem_ready = 1'b0;
    mem_data_out = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_read_enable || mem_write_enable) begin
        if (mem_write_enable) begin
          mmu_write(mem_address, mem_data_in, mem_data_width);
          m_val = 32'h0;
          m_zeros = (mem_data_width != 2'd3) ? 1 : 0;
        end else begin
          m_val = mmu_read(mem_address, mem_data_width, mem_signed_read);
          m_zeros = ((mem_data_width == 2'd1 && mem_address[0]) ||
                     (mem_data_width == 2'd3 && mem_address[1:0] != 2'b00))
                    ? 1 : 0;
        end
        m_zeros += xdelay;
        @(posedge clk); #1;
        if (m_zeros < 8) begin
          repeat (m_zeros) begin
            mem_ready = 1'b0;
            @(posedge clk); #1;
          end
          mem_ready = 1'b1;
          mem_data_out = m_val;
          @(posedge clk); #1;
          mem_ready = 1'b0;
        end
      end
    end
  end

  function automatic vec_t mk(input logic wr, input logic [2:0] f3,
                              input logic [31:0] base,
                              input logic [31:0] off,
                              input logic [31:0] wd, input int xd,
                              input logic [31:0] rd,
                              input logic [31:0] addr,
                              input logic [1:0] cause, input int lat,
                              input logic [1:0] ew, input logic es);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.base = base; v.off = off; v.wdata = wd;
    v.xd = xd; v.rdata = rd; v.addr = addr; v.cause = cause;
    v.lat = lat; v.ew = ew; v.es = es;
    return v;
  endfunction

  // Called at a negedge; drives one request and follows it to its response.
  task automatic run(input vec_t v);
    rsp_t e;
    rsp_t g;
    int   lat;
    int   nrd;
    int   nwr;
    bit   got;
    bit   issued;
    lat = 0; nrd = 0; nwr = 0; got = 0;
    issued = (v.cause == 2'd0) || (v.cause == 2'd3);
    xdelay = v.xd;
    req_write = v.wr;
    req_funct3 = v.f3;
    req_base = v.base;
    req_offset = v.off;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    chk("req_ready", 32'(req_ready), 32'd1);
    e.rdata = v.rdata;
    e.exc = (v.cause != 2'd0);
    e.cause = v.cause;
    e.addr = v.addr;
    sbq.push_back(e);
    while (!got && lat < 40) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (mem_read_enable) nrd++;
      if (mem_write_enable) nwr++;
      if (lat == 1 && issued) begin
        chk("mem_address", mem_address, v.addr);
        chk("mem_width", 32'(mem_data_width), 32'(v.ew));
        chk("mem_signed", 32'(mem_signed_read), 32'(v.es));
        if (v.wr) chk("mem_data_in", mem_data_in, v.wdata);
      end
      if (resp_valid) begin
        got = 1;
        g.rdata = resp_rdata;
        g.exc = resp_exc;
        g.cause = resp_cause;
        g.addr = resp_addr;
        e = sbq.pop_front();
        chk("resp_rdata", g.rdata, e.rdata);
        chk("resp_exc", 32'(g.exc), 32'(e.exc));
        chk("resp_cause", 32'(g.cause), 32'(e.cause));
        chk("resp_addr", g.addr, e.addr);
      end
    end
    if (!got) begin
      chk("resp_seen", 32'd0, 32'd1);
      void'(sbq.pop_front());
    end
    chk("latency", 32'(lat), 32'(v.lat));
    chk("read_pulses", 32'(nrd), (issued && !v.wr) ? 32'd1 : 32'd0);
    chk("write_pulses", 32'(nwr), (issued && v.wr) ? 32'd1 : 32'd0);
  endtask

  localparam logic [31:0] B = 32'h0100_0000;

  initial begin
    int seen;
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_funct3 = 3'b000;
    req_base = 32'h0;
    req_offset = 32'h0;
    req_wdata = 32'h0;
    ram[30'h0040_0000] = 32'h80FF_1234;
    ram[30'h0040_0001] = 32'h5566_7788;
    ram[30'h0000_0001] = 32'h1122_3344;

    vecs.push_back(mk(1'b0, 3'b000, B, 32'd3, 32'h0, 0,
                      32'hFFFF_FF80, B + 3, 2'd0, 3, 2'd0, 1'b1));
    vecs.push_back(mk(1'b0, 3'b100, B, 32'd3, 32'h0, 0,
                      32'h0000_0080, B + 3, 2'd0, 3, 2'd0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b001, B, 32'd2, 32'h0, 0,
                      32'hFFFF_80FF, B + 2, 2'd0, 3, 2'd1, 1'b1));
    vecs.push_back(mk(1'b0, 3'b101, B, 32'd0, 32'h0, 0,
                      32'h0000_1234, B, 2'd0, 3, 2'd1, 1'b0));
    vecs.push_back(mk(1'b0, 3'b010, B, 32'd0, 32'h0, 0,
                      32'h80FF_1234, B, 2'd0, 3, 2'd3, 1'b1));
    vecs.push_back(mk(1'b1, 3'b001, B, 32'd2, 32'h0000_BEEF, 0,
                      32'h0, B + 2, 2'd0, 4, 2'd1, 1'b1));
    vecs.push_back(mk(1'b0, 3'b010, B, 32'd0, 32'h0, 0,
                      32'hBEEF_1234, B, 2'd0, 3, 2'd3, 1'b1));
    vecs.push_back(mk(1'b1, 3'b010, B + 16, 32'hFFFF_FFF8, 32'hCAFE_F00D,
                      0, 32'h0, B + 8, 2'd0, 3, 2'd3, 1'b1));
    vecs.push_back(mk(1'b0, 3'b010, B, 32'd8, 32'h0, 0,
                      32'hCAFE_F00D, B + 8, 2'd0, 3, 2'd3, 1'b1));
    vecs.push_back(mk(1'b1, 3'b000, B + 8, 32'd3, 32'h1234_56AB, 0,
                      32'h0, B + 11, 2'd0, 4, 2'd0, 1'b1));
    vecs.push_back(mk(1'b0, 3'b010, B, 32'd8, 32'h0, 0,
                      32'hABFE_F00D, B + 8, 2'd0, 3, 2'd3, 1'b1));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(1'b0, 3'b010, B, 32'd1, 32'h0, 0,
                      32'h0, B + 1, 2'd1, 1, 2'd3, 1'b1));
    vecs.push_back(mk(1'b0, 3'b001, B, 32'd3, 32'h0, 0,
                      32'h0, B + 3, 2'd1, 1, 2'd1, 1'b1));
`else
    vecs.push_back(mk(1'b0, 3'b010, B, 32'd1, 32'h0, 0,
                      32'h88BE_EF12, B + 1, 2'd0, 4, 2'd3, 1'b1));
    vecs.push_back(mk(1'b0, 3'b001, B, 32'd3, 32'h0, 0,
                      32'hFFFF_88BE, B + 3, 2'd0, 4, 2'd1, 1'b1));
`endif
    vecs.push_back(mk(1'b0, 3'b011, B, 32'd0, 32'h0, 0,
                      32'h0, B, 2'd2, 1, 2'd3, 1'b1));
    vecs.push_back(mk(1'b1, 3'b100, B, 32'd4, 32'h55, 0,
                      32'h0, B + 4, 2'd2, 1, 2'd0, 1'b0));
    vecs.push_back(mk(1'b1, 3'b111, B, 32'd0, 32'h55, 0,
                      32'h0, B, 2'd2, 1, 2'd3, 1'b0));
    vecs.push_back(mk(1'b0, 3'b011, B, 32'd1, 32'h0, 0,
                      32'h0, B + 1, 2'd2, 1, 2'd3, 1'b1));
    vecs.push_back(mk(1'b0, 3'b010, 32'hFFFF_FFFC, 32'd8, 32'h0, 0,
                      32'h1122_3344, 32'h4, 2'd0, 3, 2'd3, 1'b1));
    vecs.push_back(mk(1'b0, 3'b010, B, 32'd4, 32'h0, 3,
                      32'h5566_7788, B + 4, 2'd0, 6, 2'd3, 1'b1));

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_enables", 32'({mem_read_enable, mem_write_enable}), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_width", 32'(mem_data_width), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      cur = i;
      run(vecs[i]);
    end

    cur = 100;
    run(mk(1'b0, 3'b010, B, 32'd4, 32'h0, 100,
           32'h0, B + 4, 2'd3, 6, 2'd3, 1'b1));
    @(negedge clk);
    chk("pulse_drop", 32'(resp_valid), 32'd0);
    chk("hold_cause", 32'(resp_cause), 32'd3);
    chk("hold_exc", 32'(resp_exc), 32'd1);
    chk("hold_addr", resp_addr, B + 4);
    chk("ready_after_to", 32'(req_ready), 32'd1);

    cur = 101;
    xdelay = 100;
    req_write = 1'b0;
    req_funct3 = 3'b010;
    req_base = B;
    req_offset = 32'd0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("issue_enable", 32'(mem_read_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_drop_enable", 32'(mem_read_enable), 32'd0);
    chk("rst_drop_resp", 32'(resp_valid), 32'd0);
    chk("rst_idle", 32'(req_ready), 32'd1);
    chk("rst_clr_addr", resp_addr, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid || mem_read_enable || mem_write_enable) seen++;
    end
    chk("no_stale_resp", 32'(seen), 32'd0);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage between the CPU execute stage and the `mmu`. It takes one load/store request per transaction, computes the effective address, and decodes RISC-V `funct3` into MMU width and signedness. It drives a single-pulse request into the `mmu`, waits on `mem_ready`, and returns one registered response to the CPU. It also flags illegal encodings, misaligned accesses (optional) and memory timeouts.

## Interface

**Parameters**
- `TIMEOUT`, 16: maximum WAIT cycles without `mem_ready` before a timeout exception; legal range 1..255.

**Ports**
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request strobe; sampled only while `req_ready`=1.
- `req_ready` out 1: LSU idle and able to accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V `funct3` of the load/store.
- `req_base` in 32: rs1 value.
- `req_offset` in 32: sign-extended immediate.
- `req_wdata` in 32: store data (rs2).
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: load result; 0 for stores and exceptions.
- `resp_exc` out 1: response carries an exception.
- `resp_cause` out 2: exception cause; 0 none, 1 misaligned, 2 illegal, 3 timeout.
- `resp_addr` out 32: effective address of the transaction.
- `mem_read_enable` out 1: to `mmu` `read_enable`.
- `mem_write_enable` out 1: to `mmu` `write_enable`.
- `mem_signed_read` out 1: to `mmu`.
- `mem_data_width` out 2: to `mmu`; 0 byte, 1 half, 3 word.
- `mem_address` out 32: to `mmu` `address`.
- `mem_data_in` out 32: to `mmu` `data_in`.
- `mem_data_out` in 32: from `mmu` `data_out`.
- `mem_ready` in 1: from `mmu` `mem_ready`.

## Operation

**Effective address**
- Address = `req_base` + `req_offset`, computed as a 32-bit sum that wraps modulo 2^32.

**Decode of `funct3`**
- `funct3[1:0]`: 00 → width 0, 01 → width 1, 10 → width 3.
- `funct3[1:0]`=11 is illegal.
- `mem_signed_read` = `!funct3[2]`.
- A store with `funct3[2]`=1 is illegal.

**Misalignment**
- Half access with addr[0]≠0 is misaligned.
- Word access with addr[1:0]≠0 is misaligned.
- Handling of misaligned accesses is set under Configuration.

**State machine: IDLE, ISSUE, WAIT**
- IDLE: `req_ready`=1.
  - On `req_valid`, latch address, width, signedness, write flag and wdata into the `mem_*` holding registers.
  - If the request is illegal, or misaligned with trapping enabled: pulse `resp_valid` with `resp_exc`=1 and the cause in the next cycle; stay in IDLE; no MMU enable is asserted.
  - Otherwise go to ISSUE.
- ISSUE: assert exactly one of `mem_read_enable`/`mem_write_enable` for this single cycle, then go to WAIT.
  - The enables must never be held longer than this one cycle, because the `mmu` restarts an operation whenever an enable is high in its ready state.
- WAIT: enables are 0; address, width and data are held stable; the timeout counter increments each cycle.
  - First WAIT cycle with `mem_ready`=1: capture `mem_data_out` (loads) or 0 (stores) into `resp_rdata`, pulse `resp_valid` next cycle, return to IDLE.
  - If the counter reaches `TIMEOUT` first: respond with cause 3 and return to IDLE.
- Illegal decode takes priority over misalignment.
- `req_valid` is ignored while not in IDLE.
- The CPU stalls on `req_ready`=0 or until `resp_valid`.

## Timing

**Reset values**
- All registered outputs 0.
- `req_ready`=1 (combinational from IDLE).
- The counter is cleared.

**Reset mid-operation**
- State returns to IDLE and `mem_*` enables drop immediately, because the reset is asynchronous.
- No response is produced.

**Latency** (request accepted in cycle 0)
- ISSUE is cycle 1.
- Aligned read or word write: `mem_ready` is seen in cycle 2; `resp_valid` in cycle 3.
- Half/byte write or unaligned read: `mem_ready`=0 in cycle 2, 1 in cycle 3; `resp_valid` in cycle 4.
- Exception from decode: `resp_valid` in cycle 1.

**Response and back-to-back behaviour**
- `resp_valid` is high for exactly one cycle.
- `resp_rdata`, `resp_exc`, `resp_cause` and `resp_addr` hold their values until the next response.
- A new request may be accepted in the same cycle `resp_valid` is high, since IDLE has already been re-entered.

**Timeout**
- Counter width is 8 bits.
- Timeout fires after `TIMEOUT` consecutive WAIT cycles with `mem_ready`=0.

## Configuration

- `LSU_MISALIGN_TRAP_EN` defined: misaligned half/word accesses never reach the MMU; they respond with cause 1 in cycle 1.
- `LSU_MISALIGN_TRAP_EN` undefined: misaligned accesses are issued to the `mmu` unchanged, and the `mmu` is responsible for any split access. Cause 1 is never produced.

## Test plan

1. Signed byte load, base 0x01000000, offset 3, RAM word 0x80FF1234 → width 0, signed 1, one-cycle read enable in cycle 1, `resp_valid` in cycle 3, `resp_rdata`=0xFFFFFF80.
2. Store half 0x0000BEEF at 0x01000002 with `mem_ready` low in cycle 2 → `mem_write_enable` high only in cycle 1, width 1, `resp_valid` in cycle 4, `resp_rdata`=0.
3. Word load at 0x01000001 with the macro defined → no MMU enable, `resp_exc`=1, cause 1, `resp_addr`=0x01000001 in cycle 1. Without the macro → read enable issued in cycle 1, `resp_exc`=0.
4. `funct3`=011 load, then `funct3`=100 store → each responds in cycle 1 with cause 2 and no MMU enable. Then base 0xFFFFFFFC, offset 8 → `mem_address`=0x00000004.
5. `TIMEOUT`=4 with `mem_ready` forced to 0 → response with cause 3 after 4 WAIT cycles; `req_ready` returns to 1.
6. Assert `reset_n`=0 during WAIT → enables 0 and `resp_valid` 0 immediately. After release → `req_ready`=1 and no stale response.
